// File: rtl/tm1638_key_events.sv
// tm1638_key_events: debounces the TM1638 scan vector, emits per-key pulses and queues key events.
// Auto-repeat is built only when TM1638_KEY_REPEAT_EN is defined.
module tm1638_key_events #(
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic [7:0] keys,
  output logic [7:0] keys_stable,
  output logic [7:0] key_press,
  output logic [7:0] key_release,
  output logic [7:0] key_repeat,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [3:0] event_code,
  output logic       overflow,
  input  logic       overflow_clr
);
  localparam int NK = 8;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0]         div_q, div_d;
  logic                  tick;
  logic [NK-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NK-1:0]         stable_q, press_q, release_q, repeat_q, accept, rpt;
  logic [NK-1:0]         evt, evt_pol, pending_q, pending_d, pol_q, pol_d, svc;
  logic                  overflow_q, overflow_d;
  logic [2:0]            sel;
  logic                  push, pop, full;
  logic [3:0]            push_data, code_q, code_d;
  logic [AW-1:0]         wr_q, rd_q, rd_d;
  logic [AW:0]           fcnt_q, fcnt_d;
  logic [FIFO_DEPTH-1:0][3:0] mem_q;

  assign tick  = (div_q == DW'(TICK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);

  always_comb begin
    accept = '0;
    cnt_d  = cnt_q;
    for (int k = 0; k < NK; k++) begin
      accept[k] = tick & (keys[k] ^ stable_q[k]) & (cnt_q[k] == CW'(DEBOUNCE_TICKS - 1));
      if (tick) begin
        if (keys[k] == stable_q[k] || accept[k]) cnt_d[k] = '0;
        else                                     cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end
  end

`ifdef TM1638_KEY_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  logic [NK-1:0][HW-1:0] hold_q, hold_d;

  // Counter reloads to DELAY-RATE so later repeats come every REPEAT_RATE ticks.
  always_comb begin
    hold_d = hold_q;
    rpt    = '0;
    for (int k = 0; k < NK; k++) begin
      if (!stable_q[k] || accept[k]) hold_d[k] = '0;
      else if (tick) begin
        if (hold_q[k] == HW'(REPEAT_DELAY - 1)) begin
          rpt[k]    = 1'b1;
          hold_d[k] = HW'(REPEAT_DELAY - REPEAT_RATE);
        end else begin
          hold_d[k] = hold_q[k] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  // Repeat timing is irrelevant here; the parameters stay referenced in this build.
  localparam bit RepeatCfgOk = (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);
  assign rpt = {NK{1'b0 & RepeatCfgOk}};
`endif

  // A press accept or a repeat carries new state 1; a release accept carries 0.
  assign evt     = accept | rpt;
  assign evt_pol = rpt | ~stable_q;

  assign full        = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign event_valid = (fcnt_q != '0);
  assign pop         = event_valid & event_ready;

  always_comb begin
    sel = '0;
    for (int k = NK - 1; k >= 0; k--)
      if (pending_q[k]) sel = 3'(k);
    push       = (|pending_q) & (~full | pop);
    push_data  = {pol_q[sel], sel};
    svc        = push ? (NK'(1) << sel) : '0;
    pending_d  = (pending_q & ~svc) | evt;
    pol_d      = (pol_q & ~evt) | (evt & evt_pol);
    overflow_d = (|(evt & pending_q & ~svc)) | (overflow_q & ~overflow_clr);
    rd_d       = rd_q + AW'(pop);
    fcnt_d     = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // Registered head; holds its last value while the FIFO is empty.
    code_d = code_q;
    if (fcnt_d != '0)
      code_d = (push && rd_d == wr_q) ? push_data : mem_q[rd_d];
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      pending_q  <= '0;
      pol_q      <= '0;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      mem_q      <= '0;
      code_q     <= '0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_q ^ accept;
      press_q    <= accept & ~stable_q;
      release_q  <= accept & stable_q;
      repeat_q   <= rpt;
      pending_q  <= pending_d;
      pol_q      <= pol_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + AW'(1);
      end
      rd_q       <= rd_d;
      fcnt_q     <= fcnt_d;
      code_q     <= code_d;
    end
  end

  assign keys_stable = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign event_code  = code_q;
  assign overflow    = overflow_q;
endmodule
